// File: rtl/rv32i_types.sv
// Shared RV32I types for the branch execution path: branch opcodes, the RS->BRU
// issue bundle, the CDB broadcast word and the branch resolution record.
// Latency: none (types only). Backpressure: none (types only).
package rv32i_types;

    localparam int ROB_TAG_W = 3;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5,
        BR_JAL  = 3'd6,
        BR_JALR = 3'd7
    } br_op_t;

    typedef struct packed {
        br_op_t                 operation;
        logic [31:0]            q1_data;
        logic [31:0]            q2_data;
        logic [ROB_TAG_W-1:0]   rob_dest;
        logic [31:0]            pc;
        logic                   bp_prediction;
        logic [31:0]            imm;
    } rs_br_output_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0]   rob_entry;
        logic [31:0]            rd_data;
    } cdb_t;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_W-1:0]   rob;
        logic                   taken;
        logic [31:0]            target;
        logic                   mispred;
    } br_res_t;

    function automatic logic is_jump(input br_op_t op);
        return (op == BR_JAL) || (op == BR_JALR);
    endfunction

endpackage

// File: rtl/br_cdb_fifo.sv
// FIFO of pending CDB words with occupancy count, synchronous clear and reset.
// Latency: a pushed word is visible at o_head the cycle after the push edge.
// Backpressure: none internally; the producer must never push when full without popping.
//   clk, rst       clock, synchronous active-high reset (also zeroes storage)
//   i_clear        drop all entries (push ignored, pop ignored)
//   i_push/_dat    write one word;  i_pop  remove head (ignored when empty)
//   o_head/o_empty/o_count  head word, empty flag, occupancy
module br_cdb_fifo
    import rv32i_types::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  cdb_t             i_push_dat,
    input  logic             i_pop,
    output cdb_t             o_head,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    cdb_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = i_push & ~i_clear;
    assign w_pop  = i_pop & ~i_clear & (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/br_exec_unit.sv
// Branch execution unit: resolves issued branches/jumps, reports to the ROB, queues link values for the CDB.
// Latency: resolution and CDB request appear 2 cycles after rs_result_en (issue -> E -> FIFO).
// Backpressure: unit_ready credit throttles the RS; arrivals are never stalled; CDB head held until granted.
//   clk, rst, flush                 clock, sync active-high reset, squash of all in-flight work
//   rs_result_en, rs_result         issue from the branch RS;  unit_ready  RS may issue
//   cdb_req, cdb_grant, cdb_out     CDB request/grant handshake and head word
//   br_res_*                        registered resolution record to the ROB (valid is a 1-cycle pulse)
module br_exec_unit
    import rv32i_types::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int ROB_W     = ROB_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             rs_result_en,
    input  rs_br_output_t    rs_result,
    output logic             unit_ready,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output cdb_t             cdb_out,
    output logic             br_res_valid,
    output logic [ROB_W-1:0] br_res_rob,
    output logic             br_res_taken,
    output logic [31:0]      br_res_target,
    output logic             br_res_mispred
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic          r_e_valid;
    rs_br_output_t r_e;
    br_res_t       r_res;

    logic             w_taken;
    logic [31:0]      w_pc4;
    logic [31:0]      w_target;
    logic             w_mispred;
    cdb_t             w_cdb;
    cdb_t             w_fifo_head;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [SUM_W-1:0] w_credit;

    // Resolution of the branch sitting in E.
    always_comb begin
        w_taken   = 1'b0;
        w_pc4     = r_e.pc + 32'd4;
        w_target  = w_pc4;
        w_mispred = 1'b0;
        case (r_e.operation)
            BR_BEQ:  w_taken = (r_e.q1_data == r_e.q2_data);
            BR_BNE:  w_taken = (r_e.q1_data != r_e.q2_data);
            BR_BLT:  w_taken = ($signed(r_e.q1_data) <  $signed(r_e.q2_data));
            BR_BGE:  w_taken = ($signed(r_e.q1_data) >= $signed(r_e.q2_data));
            BR_BLTU: w_taken = (r_e.q1_data <  r_e.q2_data);
            BR_BGEU: w_taken = (r_e.q1_data >= r_e.q2_data);
            default: w_taken = 1'b1;
        endcase
        if (w_taken) begin
            if (r_e.operation == BR_JALR) begin
                w_target = (r_e.q1_data + r_e.imm) & ~32'd1;
            end else begin
                w_target = r_e.pc + r_e.imm;
            end
        end
        // No target predictor exists, so JALR always redirects.
        w_mispred = (r_e.operation == BR_JALR) ? 1'b1 : (w_taken != r_e.bp_prediction);
        w_cdb.rob_entry = r_e.rob_dest;
        w_cdb.rd_data   = is_jump(r_e.operation) ? w_pc4 : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_valid <= 1'b0;
            r_e       <= '0;
            r_res     <= '0;
        end else if (flush) begin
            r_e_valid   <= 1'b0;
            r_res.valid <= 1'b0;
        end else begin
            r_e_valid   <= rs_result_en;
            r_res.valid <= r_e_valid;
            if (rs_result_en) begin
                r_e <= rs_result;
            end
            if (r_e_valid) begin
                r_res.rob     <= r_e.rob_dest;
                r_res.taken   <= w_taken;
                r_res.target  <= w_target;
                r_res.mispred <= w_mispred;
            end
        end
    end

    // E always drains into the FIFO; the credit below guarantees the slot.
    br_cdb_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (flush),
        .i_push     (r_e_valid),
        .i_push_dat (w_cdb),
        .i_pop      (cdb_req & cdb_grant),
        .o_head     (w_fifo_head),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    // Counts everything already committed to a FIFO slot: stored, in E, and arriving now.
    assign w_credit   = SUM_W'(w_fifo_count) + SUM_W'(r_e_valid) + SUM_W'(rs_result_en);
    assign unit_ready = (w_credit < SUM_W'(OUT_DEPTH));

    assign cdb_req        = ~w_fifo_empty;
    assign cdb_out        = w_fifo_head;
    assign br_res_valid   = r_res.valid;
    assign br_res_rob     = ROB_W'(r_res.rob);
    assign br_res_taken   = r_res.taken;
    assign br_res_target  = r_res.target;
    assign br_res_mispred = r_res.mispred;

endmodule

// File: tb/tb_br_exec_unit.sv
module tb_br_exec_unit;
    import rv32i_types::*;

    localparam int D = 2;

    logic          clk = 1'b0;
    logic          rst, flush, rs_result_en, cdb_grant;
    rs_br_output_t rs_result;
    logic          unit_ready, cdb_req;
    cdb_t          cdb_out;
    logic          br_res_valid, br_res_taken, br_res_mispred;
    logic [2:0]    br_res_rob;
    logic [31:0]   br_res_target;

    br_exec_unit #(.OUT_DEPTH(D), .ROB_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .rs_result_en   (rs_result_en),
        .rs_result      (rs_result),
        .unit_ready     (unit_ready),
        .cdb_req        (cdb_req),
        .cdb_grant      (cdb_grant),
        .cdb_out        (cdb_out),
        .br_res_valid   (br_res_valid),
        .br_res_rob     (br_res_rob),
        .br_res_taken   (br_res_taken),
        .br_res_target  (br_res_target),
        .br_res_mispred (br_res_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rob;
        logic        taken;
        logic [31:0] target;
        logic        mispred;
        logic [31:0] rd_data;
        int          icyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   nbcast = 0;
    int   issued = 0;
    logic last_ready = 1'b1;
    rs_br_output_t idle_item;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic rs_br_output_t mk(input br_op_t op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] rob, input logic [31:0] pc,
                                         input logic pred, input logic [31:0] imm);
        rs_br_output_t r;
        r.operation = op; r.q1_data = a; r.q2_data = b; r.rob_dest = rob;
        r.pc = pc; r.bp_prediction = pred; r.imm = imm;
        return r;
    endfunction

    // Architectural meaning of one branch, straight from the ISA rules.
    function automatic exp_t model(input rs_br_output_t r, input int ic);
        exp_t  e;
        bit    t;
        bit    jump;
        longint sa, sb;
        sa = longint'($signed(r.q1_data));
        sb = longint'($signed(r.q2_data));
        jump = (r.operation == BR_JAL) || (r.operation == BR_JALR);
        case (r.operation)
            BR_BEQ:  t = (r.q1_data == r.q2_data);
            BR_BNE:  t = (r.q1_data != r.q2_data);
            BR_BLT:  t = (sa < sb);
            BR_BGE:  t = !(sa < sb);
            BR_BLTU: t = (int'(unsigned'(r.q1_data)) < 0) ? 1'b0 : 1'b0;
            default: t = 1'b1;
        endcase
        if (r.operation == BR_BLTU) t = (longint'(r.q1_data) < longint'(r.q2_data));
        if (r.operation == BR_BGEU) t = (longint'(r.q1_data) >= longint'(r.q2_data));
        e.rob     = r.rob_dest;
        e.taken   = t;
        if (!t)                           e.target = r.pc + 32'd4;
        else if (r.operation == BR_JALR)  e.target = (r.q1_data + r.imm) & 32'hFFFF_FFFE;
        else                              e.target = r.pc + r.imm;
        e.mispred = (r.operation == BR_JALR) ? 1'b1 : (t != r.bp_prediction);
        e.rd_data = jump ? r.pc + 32'd4 : 32'd0;
        e.icyc    = ic;
        return e;
    endfunction

    // One clock cycle: drive inputs, check all outputs at the falling edge, advance the model.
    task automatic do_cycle(input logic en, input rs_br_output_t it, input logic g, input logic fl);
        exp_t hit;
        bit   found;
        bit   exp_req;
        rs_result_en = en; rs_result = it; cdb_grant = g; flush = fl;
        @(negedge clk);
        found = 1'b0;
        foreach (q[i]) if (q[i].icyc == cyc - 2) begin found = 1'b1; hit = q[i]; end
        chk("res_valid", br_res_valid, found);
        if (found) begin
            chk("res_rob", br_res_rob, hit.rob);
            chk("res_taken", br_res_taken, hit.taken);
            chk("res_target", br_res_target, hit.target);
            chk("res_mispred", br_res_mispred, hit.mispred);
        end
        exp_req = (q.size() > 0) && (q[0].icyc <= cyc - 2);
        chk("cdb_req", cdb_req, exp_req);
        if (exp_req) begin
            chk("cdb_rob", cdb_out.rob_entry, q[0].rob);
            chk("cdb_data", cdb_out.rd_data, q[0].rd_data);
        end
        chk("unit_ready", unit_ready, (q.size() + int'(en)) < D);
        last_ready = unit_ready;
        if (en) begin q.push_back(model(it, cyc)); issued++; end
        if (!fl && g && exp_req) begin void'(q.pop_front()); nbcast++; end
        if (fl) q.delete();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, idle_item, 1'b1, 1'b0);
    endtask

    initial begin
        rs_br_output_t it;
        idle_item = '0;
        rst = 1'b1; flush = 1'b0; rs_result_en = 1'b0; cdb_grant = 1'b0; rs_result = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", unit_ready, 1);
        chk("rst_req", cdb_req, 0);
        chk("rst_cdb", cdb_out, 0);
        chk("rst_valid", br_res_valid, 0);
        chk("rst_taken", br_res_taken, 0);
        chk("rst_target", br_res_target, 0);
        chk("rst_mispred", br_res_mispred, 0);
        chk("rst_rob", br_res_rob, 0);
        rst = 1'b0;

        // BEQ equal operands, predicted not-taken.
        do_cycle(1'b1, mk(BR_BEQ, 5, 5, 3'd1, 32'h100, 1'b0, 32'h20), 1'b1, 1'b0);
        do_cycle(1'b0, idle_item, 1'b1, 1'b0);
        chk("t1_valid", br_res_valid, 1);
        chk("t1_taken", br_res_taken, 1);
        chk("t1_target", br_res_target, 32'h120);
        chk("t1_mispred", br_res_mispred, 1);
        chk("t1_rd", cdb_out.rd_data, 0);
        idle(3);

        // Signed vs unsigned compare on the same operands.
        do_cycle(1'b1, mk(BR_BLT,  32'hFFFF_FFFF, 1, 3'd2, 32'h300, 1'b0, 32'h40), 1'b1, 1'b0);
        do_cycle(1'b1, mk(BR_BLTU, 32'hFFFF_FFFF, 1, 3'd3, 32'h300, 1'b0, 32'h40), 1'b1, 1'b0);
        chk("t2_blt_taken", br_res_taken, 1);
        chk("t2_blt_target", br_res_target, 32'h340);
        do_cycle(1'b0, idle_item, 1'b1, 1'b0);
        chk("t2_bltu_taken", br_res_taken, 0);
        chk("t2_bltu_target", br_res_target, 32'h304);
        chk("t2_bltu_mispred", br_res_mispred, 0);
        idle(3);

        // JALR clears bit 0 of the target and always redirects.
        do_cycle(1'b1, mk(BR_JALR, 32'h1003, 0, 3'd5, 32'h200, 1'b1, 32'h4), 1'b1, 1'b0);
        do_cycle(1'b0, idle_item, 1'b1, 1'b0);
        chk("t3_target", br_res_target, 32'h1006);
        chk("t3_mispred", br_res_mispred, 1);
        chk("t3_rd", cdb_out.rd_data, 32'h204);
        chk("t3_rob", cdb_out.rob_entry, 5);
        idle(3);

        // Grant withheld: FIFO fills and credit closes; then drains in order.
        issued = 0; nbcast = 0;
        for (int i = 0; i < 10; i++) begin
            it = mk(BR_JAL, 0, 0, 3'(i), 32'h400 + 32'(i * 4), 1'b1, 32'h10);
            do_cycle(last_ready, it, 1'b0, 1'b0);
        end
        rs_result_en = 1'b0; #1;
        chk("t4_ready_closed", unit_ready, 0);
        chk("t4_req_held", cdb_req, 1);
        chk("t4_issued", issued, D);
        for (int i = 0; i < 20 && q.size() > 0; i++) do_cycle(1'b0, idle_item, 1'b1, 1'b0);
        chk("t4_drained", q.size(), 0);
        chk("t4_bcast", nbcast, D);
        idle(2);

        // Flush with FIFO full, arrival and grant in the same cycle.
        for (int i = 0; i < 6; i++)
            do_cycle(last_ready, mk(BR_BNE, i, 0, 3'(i), 32'h500, 1'b0, 8), 1'b0, 1'b0);
        do_cycle(1'b1, mk(BR_JAL, 0, 0, 3'd7, 32'h600, 1'b1, 8), 1'b1, 1'b1);
        rs_result_en = 1'b0; flush = 1'b0; #1;
        chk("t5_req", cdb_req, 0);
        chk("t5_valid", br_res_valid, 0);
        chk("t5_ready", unit_ready, 1);
        idle(3);
        // Flush while E holds a branch.
        do_cycle(1'b1, mk(BR_BEQ, 1, 1, 3'd1, 32'h700, 1'b1, 8), 1'b1, 1'b0);
        do_cycle(1'b1, mk(BR_BEQ, 1, 2, 3'd2, 32'h700, 1'b1, 8), 1'b1, 1'b1);
        rs_result_en = 1'b0; flush = 1'b0; #1;
        chk("t5e_req", cdb_req, 0);
        chk("t5e_valid", br_res_valid, 0);
        chk("t5e_ready", unit_ready, 1);
        idle(3);

        // Back-to-back issue, grant always high: 1 per 2 cycles at depth 2.
        issued = 0;
        for (int i = 0; i < 40; i++)
            do_cycle(last_ready, mk(BR_BGE, i, 3, 3'(i), 32'h800 + 32'(i), 1'b1, 32'h30), 1'b1, 1'b0);
        chk("t6_rate", issued, 20);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            if ($urandom_range(0, 2) == 0) begin a = $urandom_range(0, 3); b = $urandom_range(0, 3); end
            it = mk(br_op_t'($urandom_range(0, 7)), a, b, 3'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), $urandom);
            do_cycle(last_ready && ($urandom_range(0, 3) != 0), it,
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end
        idle(6);

        // Reset in the middle of traffic clears everything, including held resolution fields.
        do_cycle(1'b1, mk(BR_JAL, 0, 0, 3'd4, 32'h900, 1'b0, 32'h8), 1'b0, 1'b0);
        do_cycle(1'b1, mk(BR_JAL, 0, 0, 3'd5, 32'h904, 1'b0, 32'h8), 1'b0, 1'b0);
        do_cycle(1'b0, idle_item, 1'b0, 1'b0);
        rst = 1'b1; rs_result_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; q.delete(); cyc++;
        chk("rst2_req", cdb_req, 0);
        chk("rst2_valid", br_res_valid, 0);
        chk("rst2_taken", br_res_taken, 0);
        chk("rst2_target", br_res_target, 0);
        chk("rst2_ready", unit_ready, 1);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
